// File: rtl/cpu_stack_pkg.sv
// ---------------------------------------------------------------------------
// cpu_stack_pkg
//  Shared definitions for the CPU hardware stack pointer unit.
//  Provides:
//   - default address/data widths and stack bounds
//   - FSM state encoding (IDLE / PUSH_WR / POP_RD)
//   - request decode type and helper that applies the IDLE request priority
//  No ports (package).
// ---------------------------------------------------------------------------
package cpu_stack_pkg;

  // Default geometry of the stack and its memory port
  localparam int          AW_DEF       = 16;
  localparam int          DW_DEF       = 16;
  localparam logic [15:0] SP_TOP_DEF   = 16'hFFFF;
  localparam logic [15:0] SP_LIMIT_DEF = 16'hFF00;

  // State encoding, kept as named constants so other blocks can refer to them
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PUSH_WR = 2'd1;
  localparam logic [1:0] ST_POP_RD  = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    PUSH_WR = ST_PUSH_WR,
    POP_RD  = ST_POP_RD
  } state_t;

  // What the IDLE state has been asked to do this cycle after priority
  typedef enum logic [2:0] {
    REQ_NONE,
    REQ_LD,
    REQ_BOTH,
    REQ_PUSH,
    REQ_POP
  } req_t;

  // Priority is ld, then push+pop together (a no-op), then push, then pop
  function automatic req_t decode_req(input logic ld, input logic push, input logic pop);
    req_t r;
    if (ld)
      r = REQ_LD;
    else if (push && pop)
      r = REQ_BOTH;
    else if (push)
      r = REQ_PUSH;
    else if (pop)
      r = REQ_POP;
    else
      r = REQ_NONE;
    return r;
  endfunction

endpackage

// File: rtl/stack_ptr_unit_if.sv
// ---------------------------------------------------------------------------
// stack_ptr_unit_if
//  Simple req/ack data-memory port used by the stack pointer unit.
//  Signals:
//   mem_addr  AW  word address of the current access
//   mem_wdata DW  write data
//   mem_we    1   write strobe, held until mem_ack
//   mem_re    1   read strobe, held until mem_ack
//   mem_rdata DW  read data, valid together with mem_ack
//   mem_ack   1   memory completes the current access
//  Modports:
//   master - the stack unit (drives address/data/strobes)
//   slave  - the memory (drives read data and ack)
// ---------------------------------------------------------------------------
interface stack_ptr_unit_if
  import cpu_stack_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we,
    output mem_re,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_we,
    input  mem_re,
    output mem_rdata,
    output mem_ack
  );

endinterface

// File: rtl/stack_ptr_unit_reg16_ud.sv
// ---------------------------------------------------------------------------
// reg16_ud
//  AW-bit up/down register with synchronous reset value. Holds the stack
//  pointer inside stack_ptr_unit.
//  Ports:
//   clk    in  1   clock
//   reset  in  1   synchronous active-high reset, loads RST_VAL
//   ld     in  1   load q from d (highest priority)
//   d      in  AW  load value
//   inc    in  1   q <= q + 1 (beats dec)
//   dec    in  1   q <= q - 1
//   q      out AW  register value
//  Arithmetic wraps modulo 2^AW.
// ---------------------------------------------------------------------------
module reg16_ud
  import cpu_stack_pkg::*;
#(
  parameter int            AW      = AW_DEF,
  parameter logic [AW-1:0] RST_VAL = '1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic [AW-1:0] d,
  input  logic          inc,
  input  logic          dec,
  output logic [AW-1:0] q
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  // Single register with a fixed ld > inc > dec priority; the FSM never asks
  // for more than one of these in a cycle, but the priority keeps it defined
  always_ff @(posedge clk) begin
    if (reset)
      q <= RST_VAL;
    else if (ld)
      q <= d;
    else if (inc)
      q <= q + ONE;
    else if (dec)
      q <= q - ONE;
  end

endmodule

// File: rtl/stack_ptr_unit.sv
// ---------------------------------------------------------------------------
// stack_ptr_unit
//  Full-descending hardware stack pointer for the CPU execution unit.
//  Push pre-decrements sp and writes memory; pop reads memory at sp and then
//  post-increments sp. Accesses go through a req/ack memory port, and
//  rejected pushes/pops raise sticky overflow/underflow flags.
//  Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   ld         in   1   load sp from D (IDLE only)
//   D          in   AW  sp load value
//   push       in   1   push request (IDLE only)
//   pop        in   1   pop request (IDLE only)
//   push_data  in   DW  data to push, sampled when the push is accepted
//   mem        if   --  stack_ptr_unit_if.master memory port
//   busy       out  1   high while an access is in flight
//   pop_data   out  DW  last popped word
//   pop_valid  out  1   one-cycle pulse when pop_data updates
//   sp         out  AW  current stack pointer
//   overflow   out  1   sticky, push rejected at SP_LIMIT
//   underflow  out  1   sticky, pop rejected at SP_TOP
//   sp_min     out  AW  lowest sp reached (only with SP_WATERMARK_EN)
//  Build option:
//   SP_WATERMARK_EN - adds the sp_min low-watermark output and its register.
// ---------------------------------------------------------------------------
module stack_ptr_unit
  import cpu_stack_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter logic [AW-1:0] SP_TOP   = SP_TOP_DEF,
  parameter logic [AW-1:0] SP_LIMIT = SP_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [AW-1:0]    D,
  input  logic             push,
  input  logic             pop,
  input  logic [DW-1:0]    push_data,
  stack_ptr_unit_if.master mem,
  output logic             busy,
  output logic [DW-1:0]    pop_data,
  output logic             pop_valid,
  output logic [AW-1:0]    sp,
  output logic             overflow,
  output logic             underflow
`ifdef SP_WATERMARK_EN
  ,
  output logic [AW-1:0]    sp_min
`endif
);

  localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_n;
  req_t          req;

  logic [AW-1:0] addr_q, addr_n;
  logic [DW-1:0] wdata_q, wdata_n;
  logic          we_q, we_n;
  logic          re_q, re_n;
  logic [DW-1:0] pop_data_n;
  logic          pop_valid_n;
  logic          ovf_n, unf_n;
  logic          sp_ld, sp_inc, sp_dec;
  logic [AW-1:0] sp_minus;

  // The stack pointer itself lives in the up/down register; the FSM only
  // tells it when to load, step up after a pop, or step down on a push
  reg16_ud #(
    .AW      (AW),
    .RST_VAL (SP_TOP)
  ) u_sp (
    .clk   (clk),
    .reset (reset),
    .ld    (sp_ld),
    .d     (D),
    .inc   (sp_inc),
    .dec   (sp_dec),
    .q     (sp)
  );

  assign sp_minus = sp - ONE;
  assign req      = decode_req(ld, push, pop);
  assign busy     = (state != IDLE);

  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_re    = re_q;

  // State register. Reset drops any access in flight straight back to IDLE,
  // so an ack that arrives afterwards finds the FSM idle and is ignored
  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Next-state and next-output decode. Everything holds its value by default;
  // requests are only looked at in IDLE, and the bounds checks are plain
  // equality so an sp loaded outside the normal window may wrap freely
  always_comb begin
    state_n     = state;
    addr_n      = addr_q;
    wdata_n     = wdata_q;
    we_n        = we_q;
    re_n        = re_q;
    pop_data_n  = pop_data;
    pop_valid_n = 1'b0;
    ovf_n       = overflow;
    unf_n       = underflow;
    sp_ld       = 1'b0;
    sp_inc      = 1'b0;
    sp_dec      = 1'b0;

    case (state)
      IDLE: begin
        case (req)
          REQ_LD: begin
            sp_ld = 1'b1;
            ovf_n = 1'b0;
            unf_n = 1'b0;
          end
          REQ_PUSH: begin
            if (sp == SP_LIMIT) begin
              ovf_n = 1'b1;
            end else begin
              sp_dec  = 1'b1;
              addr_n  = sp_minus;
              wdata_n = push_data;
              we_n    = 1'b1;
              state_n = PUSH_WR;
            end
          end
          REQ_POP: begin
            if (sp == SP_TOP) begin
              unf_n = 1'b1;
            end else begin
              addr_n  = sp;
              re_n    = 1'b1;
              state_n = POP_RD;
            end
          end
          default: begin
          end
        endcase
      end

      PUSH_WR: begin
        if (mem.mem_ack) begin
          we_n    = 1'b0;
          state_n = IDLE;
        end
      end

      POP_RD: begin
        if (mem.mem_ack) begin
          pop_data_n  = mem.mem_rdata;
          pop_valid_n = 1'b1;
          sp_inc      = 1'b1;
          re_n        = 1'b0;
          state_n     = IDLE;
        end
      end

      default: begin
        we_n    = 1'b0;
        re_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  // Registered memory-port outputs, pop result and sticky flags. Strobes come
  // out of flops so they rise the cycle after the request is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      we_q      <= we_n;
      re_q      <= re_n;
      pop_data  <= pop_data_n;
      pop_valid <= pop_valid_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
    end
  end

`ifdef SP_WATERMARK_EN
  // Low watermark: only a decrement can lower sp, so it is compared against
  // the post-decrement value; a load resets the mark to the loaded pointer
  always_ff @(posedge clk) begin
    if (reset)
      sp_min <= SP_TOP;
    else if (sp_ld)
      sp_min <= D;
    else if (sp_dec && (sp_minus < sp_min))
      sp_min <= sp_minus;
  end
`endif

endmodule

// File: tb/tb_stack_ptr_unit.sv
// ---------------------------------------------------------------------------
// tb_stack_ptr_unit
//  Self-checking bench for stack_ptr_unit: reset checks, a table of
//  hand-derived transactions, two hand-written multi-cycle sequences
//  (request while busy, reset during a write) and a randomized run against
//  a transaction-level stack model. Honors SP_WATERMARK_EN.
// ---------------------------------------------------------------------------
module tb_stack_ptr_unit;
  import cpu_stack_pkg::*;

  localparam logic [15:0] TOP = 16'hFFFF;
  localparam logic [15:0] LIM = 16'hFF00;

  typedef enum int {OP_NONE, OP_LD, OP_PUSH, OP_POP, OP_BOTH} op_e;

  typedef struct {
    op_e         op;
    logic [15:0] d;
    logic [15:0] data;
    int          dly;
    logic        acc;
    logic [15:0] e_addr;
    logic [15:0] e_sp;
    logic [15:0] e_pop;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld, push, pop;
  logic [15:0] D, push_data;
  logic        busy, pop_valid, overflow, underflow;
  logic [15:0] pop_data, sp;
`ifdef SP_WATERMARK_EN
  logic [15:0] sp_min;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Memory seen on the bus, and the model's idea of the stack memory
  logic [15:0] bus_mem   [logic [15:0]];
  logic [15:0] model_mem [logic [15:0]];
  logic [15:0] m_sp, m_min;
  logic        m_ovf, m_unf;

  vec_t vecs [10];

  always #5 clk = ~clk;

  stack_ptr_unit_if #(.AW(16), .DW(16)) mem_if ();

  stack_ptr_unit #(
    .AW       (16),
    .DW       (16),
    .SP_TOP   (TOP),
    .SP_LIMIT (LIM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ld        (ld),
    .D         (D),
    .push      (push),
    .pop       (pop),
    .push_data (push_data),
    .mem       (mem_if),
    .busy      (busy),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .sp        (sp),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef SP_WATERMARK_EN
    ,
    .sp_min    (sp_min)
`endif
  );

  // Unwritten memory returns an address-derived pattern
  function automatic logic [15:0] fill(input logic [15:0] a);
    return a ^ 16'h5AA5;
  endfunction

  function automatic logic [15:0] busRead(input logic [15:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : fill(a);
  endfunction

  function automatic logic [15:0] modelRead(input logic [15:0] a);
    return model_mem.exists(a) ? model_mem[a] : fill(a);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input op_e op, input logic [15:0] d, input logic [15:0] data);
    ld        = (op == OP_LD);
    push      = (op == OP_PUSH) || (op == OP_BOTH);
    pop       = (op == OP_POP)  || (op == OP_BOTH);
    D         = d;
    push_data = data;
  endtask

  task automatic modelReset();
    m_sp  = TOP;
    m_min = TOP;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // Stack model: sp rules applied directly, expectations for one transaction
  task automatic modelStep(input op_e op, input logic [15:0] d, input logic [15:0] data,
                           input int dly, output vec_t v);
    v.op = op; v.d = d; v.data = data; v.dly = dly;
    v.acc = 1'b0; v.e_addr = 16'h0; v.e_pop = 16'h0;
    case (op)
      OP_LD: begin
        m_sp = d; m_min = d; m_ovf = 1'b0; m_unf = 1'b0;
      end
      OP_PUSH: begin
        if (m_sp == LIM) m_ovf = 1'b1;
        else begin
          m_sp = m_sp - 16'd1;
          model_mem[m_sp] = data;
          if (m_sp < m_min) m_min = m_sp;
          v.acc = 1'b1; v.e_addr = m_sp;
        end
      end
      OP_POP: begin
        if (m_sp == TOP) m_unf = 1'b1;
        else begin
          v.acc = 1'b1; v.e_addr = m_sp; v.e_pop = modelRead(m_sp);
          m_sp = m_sp + 16'd1;
        end
      end
      default: begin
      end
    endcase
    v.e_sp = m_sp; v.e_ovf = m_ovf; v.e_unf = m_unf;
  endtask

  task automatic checkFlags(input logic [15:0] e_sp, input logic e_ovf, input logic e_unf);
    checkOutput("sp", sp, e_sp);
    checkOutput("overflow", 16'(overflow), 16'(e_ovf));
    checkOutput("underflow", 16'(underflow), 16'(e_unf));
  endtask

  // One transaction from IDLE, acting as the memory when an access starts
  task automatic runTxn(input vec_t v);
    applyStimulus(v.op, v.d, v.data);
    @(posedge clk); #1;
    applyStimulus(OP_NONE, 16'h0, 16'h0);
    if (v.acc) begin
      checkOutput("busy_acc", 16'(busy), 16'd1);
      checkOutput("we_acc", 16'(mem_if.mem_we), 16'(v.op == OP_PUSH));
      checkOutput("re_acc", 16'(mem_if.mem_re), 16'(v.op == OP_POP));
      checkOutput("addr", mem_if.mem_addr, v.e_addr);
      checkOutput("sp_acc", sp, v.e_addr);
      if (v.op == OP_PUSH) checkOutput("wdata", mem_if.mem_wdata, v.data);
      for (int k = 0; k < v.dly; k++) begin
        @(posedge clk); #1;
        checkOutput("hold_strobe", 16'(mem_if.mem_we ^ mem_if.mem_re), 16'd1);
        checkOutput("hold_addr", mem_if.mem_addr, v.e_addr);
      end
      mem_if.mem_ack = 1'b1;
      if (mem_if.mem_we) bus_mem[mem_if.mem_addr] = mem_if.mem_wdata;
      mem_if.mem_rdata = busRead(mem_if.mem_addr);
      @(posedge clk); #1;
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 16'($urandom);
      checkOutput("busy_done", 16'(busy), 16'd0);
      checkOutput("strobes_done", 16'({mem_if.mem_we, mem_if.mem_re}), 16'd0);
      checkOutput("pop_valid", 16'(pop_valid), 16'(v.op == OP_POP));
      if (v.op == OP_POP) checkOutput("pop_data", pop_data, v.e_pop);
      @(posedge clk); #1;
      checkOutput("pop_valid_pulse", 16'(pop_valid), 16'd0);
    end else begin
      checkOutput("busy_idle", 16'(busy), 16'd0);
      checkOutput("strobes_idle", 16'({mem_if.mem_we, mem_if.mem_re}), 16'd0);
      checkOutput("pop_valid_idle", 16'(pop_valid), 16'd0);
    end
    checkFlags(v.e_sp, v.e_ovf, v.e_unf);
`ifdef SP_WATERMARK_EN
    checkOutput("sp_min", sp_min, m_min);
`endif
  endtask

  initial begin
    vec_t  scratch;
    vec_t  v;
    op_e   op;
    logic [15:0] d, data;
    int    sel;

    // op, d, data, dly, acc, e_addr, e_sp, e_pop, e_ovf, e_unf
    vecs[0] = '{OP_PUSH, 16'h0000, 16'h1234, 1, 1'b1, 16'hFFFE, 16'hFFFE, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{OP_POP,  16'h0000, 16'h0000, 0, 1'b1, 16'hFFFE, 16'hFFFF, 16'h1234, 1'b0, 1'b0};
    vecs[2] = '{OP_POP,  16'h0000, 16'h0000, 0, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    vecs[3] = '{OP_LD,   16'hFF00, 16'h0000, 0, 1'b0, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{OP_PUSH, 16'h0000, 16'hBEEF, 0, 1'b0, 16'h0000, 16'hFF00, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{OP_BOTH, 16'h0000, 16'h7777, 0, 1'b0, 16'h0000, 16'hFF00, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{OP_LD,   16'hFF01, 16'h0000, 0, 1'b0, 16'h0000, 16'hFF01, 16'h0000, 1'b0, 1'b0};
    vecs[7] = '{OP_PUSH, 16'h0000, 16'hCAFE, 2, 1'b1, 16'hFF00, 16'hFF00, 16'h0000, 1'b0, 1'b0};
    vecs[8] = '{OP_PUSH, 16'h0000, 16'h0001, 0, 1'b0, 16'h0000, 16'hFF00, 16'h0000, 1'b1, 1'b0};
    vecs[9] = '{OP_POP,  16'h0000, 16'h0000, 3, 1'b1, 16'hFF00, 16'hFF01, 16'hCAFE, 1'b1, 1'b0};

    reset = 1'b1;
    applyStimulus(OP_NONE, 16'h0, 16'h0);
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 16'h0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    $display("[TB] reset state");
    checkFlags(16'hFFFF, 1'b0, 1'b0);
    checkOutput("rst_busy", 16'(busy), 16'd0);
    checkOutput("rst_strobes", 16'({mem_if.mem_we, mem_if.mem_re}), 16'd0);
    checkOutput("rst_addr", mem_if.mem_addr, 16'h0000);
    checkOutput("rst_wdata", mem_if.mem_wdata, 16'h0000);
    checkOutput("rst_pop_data", pop_data, 16'h0000);
    checkOutput("rst_pop_valid", 16'(pop_valid), 16'd0);
`ifdef SP_WATERMARK_EN
    checkOutput("rst_sp_min", sp_min, 16'hFFFF);
`endif

    $display("[TB] table vectors");
    for (int i = 0; i < 10; i++) begin
      modelStep(vecs[i].op, vecs[i].d, vecs[i].data, vecs[i].dly, scratch);
      runTxn(vecs[i]);
    end

    // Requests arriving while a push is in flight must be ignored
    $display("[TB] requests while busy");
    modelStep(OP_PUSH, 16'h0, 16'h1111, 0, scratch);
    applyStimulus(OP_PUSH, 16'h0, 16'h1111);
    @(posedge clk); #1;
    checkOutput("busy_seq_we", 16'(mem_if.mem_we), 16'd1);
    checkOutput("busy_seq_addr", mem_if.mem_addr, 16'hFF00);
    applyStimulus(OP_PUSH, 16'h0, 16'h2222);
    @(posedge clk); #1;
    checkOutput("busy_push_sp", sp, 16'hFF00);
    checkOutput("busy_push_wdata", mem_if.mem_wdata, 16'h1111);
    checkOutput("busy_push_addr", mem_if.mem_addr, 16'hFF00);
    applyStimulus(OP_POP, 16'h0, 16'h0);
    @(posedge clk); #1;
    checkOutput("busy_pop_re", 16'(mem_if.mem_re), 16'd0);
    checkOutput("busy_pop_sp", sp, 16'hFF00);
    applyStimulus(OP_LD, 16'h0123, 16'h0);
    @(posedge clk); #1;
    checkOutput("busy_ld_sp", sp, 16'hFF00);
    applyStimulus(OP_NONE, 16'h0, 16'h0);
    mem_if.mem_ack = 1'b1;
    bus_mem[mem_if.mem_addr] = mem_if.mem_wdata;
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0;
    checkOutput("busy_end", 16'(busy), 16'd0);
    checkFlags(16'hFF00, 1'b1, 1'b0);

    // Reset during a write with ack withheld, then a late ack
    $display("[TB] reset during write");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    modelReset();
    applyStimulus(OP_PUSH, 16'h0, 16'h5A5A);
    @(posedge clk); #1;
    applyStimulus(OP_NONE, 16'h0, 16'h0);
    checkOutput("abort_we_before", 16'(mem_if.mem_we), 16'd1);
    checkOutput("abort_sp_before", sp, 16'hFFFE);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("abort_we", 16'(mem_if.mem_we), 16'd0);
    checkOutput("abort_busy", 16'(busy), 16'd0);
    checkOutput("abort_addr", mem_if.mem_addr, 16'h0000);
    checkOutput("abort_sp", sp, 16'hFFFF);
    mem_if.mem_ack   = 1'b1;
    mem_if.mem_rdata = 16'hDEAD;
    @(posedge clk); #1;
    mem_if.mem_ack = 1'b0;
    checkOutput("late_ack_busy", 16'(busy), 16'd0);
    checkOutput("late_ack_strobes", 16'({mem_if.mem_we, mem_if.mem_re}), 16'd0);
    checkOutput("late_ack_pop_valid", 16'(pop_valid), 16'd0);
    checkOutput("late_ack_pop_data", pop_data, 16'h0000);
    checkFlags(16'hFFFF, 1'b0, 1'b0);

    // Randomized transactions against the stack model
    $display("[TB] random transactions");
    bus_mem.delete();
    model_mem.delete();
    for (int t = 0; t < 300; t++) begin
      sel  = $urandom_range(0, 9);
      data = 16'($urandom);
      d    = 16'h0;
      if (sel == 0) begin
        op = OP_LD;
        case ($urandom_range(0, 3))
          0:       d = LIM + 16'($urandom_range(0, 3));
          1:       d = TOP - 16'($urandom_range(0, 3));
          2:       d = 16'($urandom);
          default: d = 16'h0001;
        endcase
      end else if (sel == 1) op = OP_BOTH;
      else if (sel == 2)     op = OP_NONE;
      else if (sel <= 6)     op = OP_PUSH;
      else                   op = OP_POP;
      modelStep(op, d, data, int'($urandom_range(0, 3)), v);
      runTxn(v);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
